// File: rtl/load_unit.sv
// -----------------------------------------------------------------------------
// load_unit
//   Load stage between execute/decode and memController read port 3.
//   It accepts one load command, runs the request3/done3 handshake, then
//   selects the byte lane of the big-endian word and sign- or zero-extends it.
//   The result goes out as a single register-file write. A watchdog turns a
//   missing done3 into a timeout fault.
//
//   Optional feature macro: LOAD_ALIGN_CHECK_EN
//     When defined, a word load with ld_addr[0]=1 is rejected in IDLE with a
//     misaligned fault, and no memory request is issued.
//
// Parameters
//   DEST_W   width of destination register index
//   TIMEOUT  cycles in WAIT before timeout fault; 0 disables the watchdog
//   TMO_W    watchdog counter width; 2**TMO_W must exceed TIMEOUT
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   ld_start/addr/byte/signed/dest  load command (sampled when ld_busy=0)
//   ld_busy                      command in flight
//   mem_addr, mem_request        to memController addr3 / request3
//   mem_done, mem_readdat        from memController done3 / readdat3
//   wb_valid, wb_dest, wb_data   one-cycle register-file write
//   ld_fault, ld_fault_code      one-cycle fault pulse; code held until next
//                                fault (01 timeout, 10 misaligned)
// -----------------------------------------------------------------------------
module load_unit #(
    parameter int DEST_W  = 3,
    parameter int TIMEOUT = 64,
    parameter int TMO_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_start,
    input  logic [15:0]       ld_addr,
    input  logic              ld_byte,
    input  logic              ld_signed,
    input  logic [DEST_W-1:0] ld_dest,
    output logic              ld_busy,
    output logic [15:0]       mem_addr,
    output logic              mem_request,
    input  logic              mem_done,
    input  logic [15:0]       mem_readdat,
    output logic              wb_valid,
    output logic [DEST_W-1:0] wb_dest,
    output logic [15:0]       wb_data,
    output logic              ld_fault,
    output logic [1:0]        ld_fault_code
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] CODE_TIMEOUT    = 2'b01;
    localparam logic [1:0] CODE_MISALIGNED = 2'b10;

    // Last counter value before the fault fires; guarded so TIMEOUT=0 is legal.
    localparam int              TMO_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TMO_W-1:0] TMO_LAST_V = TMO_W'(TMO_LAST);

    // State and registered outputs
    state_t              r_state;
    logic [15:0]         r_mem_addr;
    logic                r_mem_request;
    logic                r_wb_valid;
    logic [DEST_W-1:0]   r_wb_dest;
    logic [15:0]         r_wb_data;
    logic                r_fault;
    logic [1:0]          r_fault_code;
    logic [TMO_W-1:0]    r_cnt;

    // Command fields latched at acceptance
    logic                r_addr0;
    logic                r_byte;
    logic                r_signed;
    logic [DEST_W-1:0]   r_dest;

    // Next-state values
    state_t              w_state_nxt;
    logic [15:0]         w_mem_addr_nxt;
    logic                w_mem_request_nxt;
    logic                w_wb_valid_nxt;
    logic [DEST_W-1:0]   w_wb_dest_nxt;
    logic [15:0]         w_wb_data_nxt;
    logic                w_fault_nxt;
    logic [1:0]          w_fault_code_nxt;
    logic [TMO_W-1:0]    w_cnt_nxt;
    logic                w_addr0_nxt;
    logic                w_byte_nxt;
    logic                w_signed_nxt;
    logic [DEST_W-1:0]   w_dest_nxt;

    logic                w_misaligned;
    logic                w_tmo_hit;
    logic [7:0]          w_lane;
    logic [15:0]         w_ext;

`ifdef LOAD_ALIGN_CHECK_EN
    assign w_misaligned = ~ld_byte & ld_addr[0];
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_tmo_hit = (TIMEOUT != 0) && (r_cnt == TMO_LAST_V);

    // Big-endian word: even byte address lives in the high half.
    assign w_lane = r_addr0 ? mem_readdat[7:0] : mem_readdat[15:8];
    assign w_ext  = !r_byte   ? mem_readdat :
                    r_signed  ? {{8{w_lane[7]}}, w_lane} :
                                {8'h00, w_lane};

    // NOTE: every variable gets its default before the case; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        w_state_nxt       = r_state;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_request_nxt = r_mem_request;
        w_wb_valid_nxt    = 1'b0;
        w_wb_dest_nxt     = r_wb_dest;
        w_wb_data_nxt     = r_wb_data;
        w_fault_nxt       = 1'b0;
        w_fault_code_nxt  = r_fault_code;
        w_cnt_nxt         = r_cnt;
        w_addr0_nxt       = r_addr0;
        w_byte_nxt        = r_byte;
        w_signed_nxt      = r_signed;
        w_dest_nxt        = r_dest;

        case (r_state)
            S_IDLE: begin
                // mem_done is deliberately not looked at here, so a stale
                // done3 from an abandoned read cannot produce a write.
                if (ld_start) begin
                    if (w_misaligned) begin
                        w_fault_nxt      = 1'b1;
                        w_fault_code_nxt = CODE_MISALIGNED;
                    end else begin
                        w_state_nxt       = S_WAIT;
                        w_mem_addr_nxt    = ld_addr;
                        w_mem_request_nxt = 1'b1;
                        w_cnt_nxt         = '0;
                        w_addr0_nxt       = ld_addr[0];
                        w_byte_nxt        = ld_byte;
                        w_signed_nxt      = ld_signed;
                        w_dest_nxt        = ld_dest;
                    end
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    // memController drops done3 on this same edge.
                    w_mem_request_nxt = 1'b0;
                    w_wb_valid_nxt    = 1'b1;
                    w_wb_dest_nxt     = r_dest;
                    w_wb_data_nxt     = w_ext;
                    w_state_nxt       = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + TMO_W'(1);
                    if (w_tmo_hit) begin
                        w_mem_request_nxt = 1'b0;
                        w_fault_nxt       = 1'b1;
                        w_fault_code_nxt  = CODE_TIMEOUT;
                        w_state_nxt       = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt       = S_IDLE;
                w_mem_request_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_mem_addr    <= '0;
            r_mem_request <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_dest     <= '0;
            r_wb_data     <= '0;
            r_fault       <= 1'b0;
            r_fault_code  <= '0;
            r_cnt         <= '0;
            r_addr0       <= 1'b0;
            r_byte        <= 1'b0;
            r_signed      <= 1'b0;
            r_dest        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_request <= w_mem_request_nxt;
            r_wb_valid    <= w_wb_valid_nxt;
            r_wb_dest     <= w_wb_dest_nxt;
            r_wb_data     <= w_wb_data_nxt;
            r_fault       <= w_fault_nxt;
            r_fault_code  <= w_fault_code_nxt;
            r_cnt         <= w_cnt_nxt;
            r_addr0       <= w_addr0_nxt;
            r_byte        <= w_byte_nxt;
            r_signed      <= w_signed_nxt;
            r_dest        <= w_dest_nxt;
        end
    end

    assign ld_busy       = (r_state != S_IDLE);
    assign mem_addr      = r_mem_addr;
    assign mem_request   = r_mem_request;
    assign wb_valid      = r_wb_valid;
    assign wb_dest       = r_wb_dest;
    assign wb_data       = r_wb_data;
    assign ld_fault      = r_fault;
    assign ld_fault_code = r_fault_code;

endmodule
